// File: rtl/ex_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_pkg
//  Purpose  : Shared types and constants for the EX->MEM pipeline register.
//             ctrl_t carries the MEM/WB control bits and flags_t the NZCV
//             condition flags.
//  Revision : 1.0  initial release
// ============================================================================
package ex_mem_pkg;

    // MEM/WB controls. reg_write is the MSB, so {1,0,0,0} is a plain ALU
    // writeback.
    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_read;
        logic mem_to_reg;
    } ctrl_t;

    // Condition flags. n is the MSB, so Z|C reads as 4'b0110.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // All-zero controls. A bubble carrying these can never write the
    // register file or memory.
    localparam ctrl_t  CTRL_NOP    = '0;
    localparam flags_t FLAGS_RESET = 4'b0000;

endpackage : ex_mem_pkg
`default_nettype wire

// File: rtl/en_dff_bus.sv
`default_nettype none
// ============================================================================
//  Module   : en_dff_bus
//  Purpose  : A WIDTH-bit bus of D flip-flops with a load enable. Each bit has
//             an enable mux in front of it. The asynchronous active-low reset
//             clears every bit to zero.
//  Ports    : clk    in   rising-edge clock
//             rst_n  in   asynchronous reset, active-low
//             i_en   in   1 = capture i_d on the edge, 0 = hold
//             i_d    in   WIDTH-bit next value
//             o_q    out  WIDTH-bit registered value
//  Revision : 1.0  initial release
// ============================================================================
module en_dff_bus #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_d;

    // Each bit has its own hold mux. This keeps the enable local to the bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_d[i] = i_en ? i_d[i] : r_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_d;
        end
    end

    assign o_q = r_q;

endmodule : en_dff_bus
`default_nettype wire

// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_reg
//  Purpose  : EX->MEM pipeline register of the 5-stage LEGv8 pipeline.
//             It captures the ALU result, the store data, the destination
//             register and the MEM/WB controls. It also owns the
//             architectural NZCV register, and it provides a zero-cycle flag
//             bypass so that a B.cond in ID sees the flags of the ADDS/SUBS
//             that is currently in EX.
//  Ports    : clk, reset_n                  clock / async active-low reset
//             stall, flush                  hold all state / squash the entry
//             ex_valid, ex_alu_result,
//             ex_store_data, ex_rd, ex_ctrl,
//             ex_set_flags, ex_flags        EX-stage inputs
//             mem_valid, mem_alu_result,
//             mem_store_data, mem_rd,
//             mem_ctrl                      MEM-stage registered outputs
//             flags_q                       architectural NZCV
//             flags_fwd                     combinational NZCV bypass
//  Revision : 1.0  initial release
// ============================================================================
module ex_mem_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_SIZE = 64,
    parameter int REG_BITS  = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 ex_valid,
    input  logic [DATA_SIZE-1:0] ex_alu_result,
    input  logic [DATA_SIZE-1:0] ex_store_data,
    input  logic [REG_BITS-1:0]  ex_rd,
    input  ctrl_t                ex_ctrl,
    input  logic                 ex_set_flags,
    input  flags_t               ex_flags,
    output logic                 mem_valid,
    output logic [DATA_SIZE-1:0] mem_alu_result,
    output logic [DATA_SIZE-1:0] mem_store_data,
    output logic [REG_BITS-1:0]  mem_rd,
    output ctrl_t                mem_ctrl,
    output flags_t               flags_q,
    output flags_t               flags_fwd
);

    logic   w_load;
    logic   w_valid_d;
    ctrl_t  w_ctrl_d;
    logic   w_flags_en;

    // Stall has priority over flush. A squash only takes effect on a cycle
    // where the stage advances. On a flush the data and rd fields still load:
    // their value is a don't-care once valid and ctrl are cleared.
    always_comb begin
        w_load     = !stall;
        w_valid_d  = ex_valid && !flush;
        w_ctrl_d   = w_valid_d ? ex_ctrl : CTRL_NOP;
        w_flags_en = ex_valid && ex_set_flags && !stall && !flush;
    end

    // The bypass uses the same condition that commits the flags. ID can
    // therefore never see flags that will not be committed.
    assign flags_fwd = w_flags_en ? ex_flags : flags_q;

    en_dff_bus #(.WIDTH(1)) u_valid (
        .clk   (clk),
        .rst_n (reset_n),
        .i_en  (w_load),
        .i_d   (w_valid_d),
        .o_q   (mem_valid)
    );

    en_dff_bus #(.WIDTH(DATA_SIZE)) u_result (
        .clk   (clk),
        .rst_n (reset_n),
        .i_en  (w_load),
        .i_d   (ex_alu_result),
        .o_q   (mem_alu_result)
    );

    en_dff_bus #(.WIDTH(DATA_SIZE)) u_store (
        .clk   (clk),
        .rst_n (reset_n),
        .i_en  (w_load),
        .i_d   (ex_store_data),
        .o_q   (mem_store_data)
    );

    en_dff_bus #(.WIDTH(REG_BITS)) u_rd (
        .clk   (clk),
        .rst_n (reset_n),
        .i_en  (w_load),
        .i_d   (ex_rd),
        .o_q   (mem_rd)
    );

    en_dff_bus #(.WIDTH($bits(ctrl_t))) u_ctrl (
        .clk   (clk),
        .rst_n (reset_n),
        .i_en  (w_load),
        .i_d   (w_ctrl_d),
        .o_q   (mem_ctrl)
    );

    en_dff_bus #(.WIDTH($bits(flags_t))) u_flags (
        .clk   (clk),
        .rst_n (reset_n),
        .i_en  (w_flags_en),
        .i_d   (ex_flags),
        .o_q   (flags_q)
    );

endmodule : ex_mem_reg
`default_nettype wire
